// File: rtl/lsu_sequencer.sv
// lsu_sequencer: sequences decoded loads/stores onto a single-port 32-bit data bus
module lsu_sequencer #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        issue_valid,
  output logic        issue_ready,
  input  logic        ren,
  input  logic        wen,
  input  logic [3:0]  rw_type,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [4:0]  rd_in,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        done,
  output logic        rd_we,
  output logic [4:0]  rd_out,
  output logic [31:0] rd_data,
  output logic        err,
  output logic [1:0]  err_code
);
  typedef enum logic [1:0] {IDLE, BUS, DONE, ERR} state_t;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT == 0 ? 0 : TIMEOUT - 1);
  state_t state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic we_q, u_q, w_q, h_q;
  logic [1:0] off_q, code_q;
  logic [31:0] addr_q, wdata_q, rdata_q, sh, result;
  logic [3:0] be_q, be_nx;
  logic [31:0] wdata_nx;
  logic [15:0] half;
  logic [4:0] rd_q;
  logic accept, illegal, misalign, timeout;
  always_comb begin
    accept = issue_valid & issue_ready & (ren ^ wen);
    illegal = !$onehot(rw_type[2:0]) | (rw_type[3] & (rw_type[2] | wen));
    misalign = (rw_type[2] & |addr[1:0]) | (rw_type[1] & addr[0]);
    timeout = (TIMEOUT != 0) && (cnt == LAST);
    be_nx = rw_type[2] ? 4'b1111 : rw_type[1] ? (addr[1] ? 4'b1100 : 4'b0011) : 4'b0001 << addr[1:0];
    wdata_nx = !wen ? '0 : rw_type[2] ? wdata : rw_type[1] ? {2{wdata[15:0]}} : {4{wdata[7:0]}};
    state_nx = state == IDLE ? (accept ? (illegal | misalign ? ERR : BUS) : IDLE)
             : state == BUS ? (mem_ack ? DONE : timeout ? ERR : BUS)
             : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      we_q <= 1'b0;
      u_q <= 1'b0;
      w_q <= 1'b0;
      h_q <= 1'b0;
      off_q <= '0;
      code_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      be_q <= '0;
      rd_q <= '0;
    end else begin
      state <= state_nx;
      cnt <= state == BUS ? cnt + 1'b1 : '0;
      if (accept) begin
        we_q <= wen;
        u_q <= rw_type[3];
        w_q <= rw_type[2];
        h_q <= rw_type[1];
        off_q <= addr[1:0];
        addr_q <= {addr[31:2], 2'b00};
        be_q <= be_nx;
        wdata_q <= wdata_nx;
        rd_q <= rd_in;
        code_q <= illegal ? 2'd3 : misalign ? 2'd1 : 2'd0;
      end
      if (state == BUS && mem_ack) rdata_q <= mem_rdata;
      if (state == BUS && !mem_ack && timeout) code_q <= 2'd2;
    end
  end
  // lane select uses the byte offset latched at accept
  always_comb begin
    sh = rdata_q >> {off_q, 3'b000};
    half = off_q[1] ? rdata_q[31:16] : rdata_q[15:0];
    result = w_q ? rdata_q
           : h_q ? {{16{~u_q & half[15]}}, half}
           : {{24{~u_q & sh[7]}}, sh[7:0]};
    issue_ready = state == IDLE;
    mem_req = state == BUS;
    mem_we = mem_req & we_q;
    mem_addr = mem_req ? addr_q : '0;
    mem_be = mem_req ? be_q : '0;
    mem_wdata = mem_req ? wdata_q : '0;
    done = state == DONE;
    rd_we = done & ~we_q;
    rd_out = rd_we ? rd_q : '0;
    rd_data = rd_we ? result : '0;
    err = state == ERR;
    err_code = err ? code_q : '0;
  end
endmodule
